// File: rtl/keypad_pkg.sv
// keypad_pkg: keypad layout lookups, emulator FSM states and bounce LFSR constants
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, PRESS, RELEASE, GAP} state_t;
  typedef struct packed {
    logic [1:0] r;
    logic [1:0] c;
  } rc_t;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [3:0] LAYOUT [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };
  function automatic logic [3:0] rc_to_key(input rc_t rc);
    return LAYOUT[rc.r][rc.c];
  endfunction
  function automatic rc_t key_to_rc(input logic [3:0] k);
    rc_t rc;
    rc = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (LAYOUT[r][c] == k) rc = '{r: 2'(r), c: 2'(c)};
    return rc;
  endfunction
endpackage

// File: rtl/keypad_lfsr.sv
// keypad_lfsr: 8-bit Fibonacci LFSR (taps 8,6,5,4) for contact bounce; built only with KEYPAD_EMU_BOUNCE_EN
`ifdef KEYPAD_EMU_BOUNCE_EN
module keypad_lfsr
  import keypad_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  output logic o_bit
);
  logic [7:0] r_q;
  always_ff @(posedge i_clk) r_q <= i_rst ? LFSR_SEED : {r_q[6:0], ^(r_q & LFSR_TAPS)};
  assign o_bit = r_q[0];
endmodule
`endif

// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 keypad responder pressing a handshaken key for a timed hold; define KEYPAD_EMU_BOUNCE_EN for contact bounce
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES   = 2_000_000,
  parameter int GAP_CYCLES    = 1_000_000,
  parameter int BOUNCE_CYCLES = 50_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [3:0] col,
  input  logic [3:0] key_code,
  input  logic       press_valid,
  output logic       press_ready,
  output logic [3:0] row,
  output logic       busy,
  output logic       done
);
  localparam int HOLD = HOLD_CYCLES < 1 ? 1 : HOLD_CYCLES;
  localparam int GAPN = GAP_CYCLES < 1 ? 1 : GAP_CYCLES;
  localparam int BNC  = BOUNCE_CYCLES < 1 ? 1 : BOUNCE_CYCLES;
  localparam int MAXP = HOLD > GAPN ? (HOLD > BNC ? HOLD : BNC) : (GAPN > BNC ? GAPN : BNC);
  localparam int CW   = $clog2(MAXP) + 1;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_load;
  rc_t r_key;
  logic r_contact, w_contact, r_done, w_fire, w_last, w_rel_end, w_press_c, w_rel_c;
  logic [3:0] r_row, w_row;
  assign w_fire = press_valid && press_ready;
  assign w_last = r_cnt == CW'(1);
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [CW-1:0] REL_LOAD = CW'(BNC);
  logic w_lfsr;
  keypad_lfsr u_lfsr (.i_clk(clk_100MHz), .i_rst(reset), .o_bit(w_lfsr));
  // cnt counts down from HOLD, so the first BNC cycles of PRESS satisfy cnt + BNC > HOLD
  assign w_press_c = int'(r_cnt) + BNC > HOLD ? w_lfsr : 1'b1;
  assign w_rel_c   = w_lfsr;
  assign w_rel_end = w_last;
`else
  localparam logic [CW-1:0] REL_LOAD = CW'(1);
  assign w_press_c = 1'b1;
  assign w_rel_c   = 1'b0;
  assign w_rel_end = 1'b1;
`endif
  always_ff @(posedge clk_100MHz)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_fire) w_next = PRESS;
      PRESS:   if (w_last) w_next = RELEASE;
      RELEASE: if (w_rel_end) w_next = GAP;
      default: if (w_last) w_next = IDLE;
    endcase
  end
  always_comb begin
    press_ready = r_state == IDLE && !reset;
    busy = r_state != IDLE;
    w_contact = r_state == PRESS ? w_press_c : (r_state == RELEASE && w_rel_c);
    w_load = w_next == PRESS ? CW'(HOLD) : w_next == GAP ? CW'(GAPN) : REL_LOAD;
    w_row = 4'hF;
    if (r_contact && !col[~r_key.c]) w_row[~r_key.r] = 1'b0;
  end
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_cnt <= '0;
      r_key <= '0;
      r_contact <= 1'b0;
      r_row <= 4'hF;
      r_done <= 1'b0;
    end else begin
      r_cnt <= w_next != r_state ? w_load : r_state == IDLE ? r_cnt : r_cnt - CW'(1);
      if (w_fire) r_key <= key_to_rc(key_code);
      r_contact <= w_contact;
      r_row <= w_row;
      r_done <= r_state == GAP && w_last;
    end
  end
  assign row  = r_row;
  assign done = r_done;
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed checks of handshake, row timing, hold/gap lengths and reset behaviour
module tb_keypad_emulator;
  logic clk = 1'b0, reset = 1'b1, press_valid = 1'b0;
  logic press_ready, busy, done;
  logic [3:0] col = 4'hF, key_code = 4'h0, row;
  int n_vec = 0, n_err = 0;
  keypad_emulator #(.HOLD_CYCLES(8), .GAP_CYCLES(4), .BOUNCE_CYCLES(2)) dut (
    .clk_100MHz(clk), .reset(reset), .col(col), .key_code(key_code),
    .press_valid(press_valid), .press_ready(press_ready), .row(row), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (!press_ready && t < 100) begin
      tick();
      t++;
    end
    if (!press_ready) begin
      $display("FAIL %s: press_ready still %b after %0d cycles, required 1", nm, press_ready, t);
      $fatal(1, "idle timeout");
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    press_valid = 1'b1;
    key_code = 4'h5;
    col = 4'b1011;
    tick();
    tick();
    n_vec++; if (row !== 4'hF) begin n_err++; $display("FAIL reset_row: got %b, required 1111", row); end
    n_vec++; if (press_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b, required 0", press_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, required 0", done); end
    reset = 1'b0;
    #1;
    n_vec++; if (press_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b, required 1", press_ready); end
    tick();
    press_valid = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL handshake_busy: got %b, required 1", busy); end
    n_vec++; if (press_ready !== 1'b0) begin n_err++; $display("FAIL handshake_ready: got %b, required 0", press_ready); end
  endtask
  task automatic test_col_track();
    tick();
    n_vec++; if (row !== 4'hF) begin n_err++; $display("FAIL key5_edge1: got %b, required 1111", row); end
    tick();
    n_vec++; if (row !== 4'b1011) begin n_err++; $display("FAIL key5_edge2: got %b, required 1011", row); end
    col = 4'b0111;
    tick();
    n_vec++; if (row !== 4'hF) begin n_err++; $display("FAIL key5_other_col: got %b, required 1111", row); end
    col = 4'b1011;
    tick();
    n_vec++; if (row !== 4'b1011) begin n_err++; $display("FAIL key5_col_back: got %b, required 1011", row); end
    wait_idle("key5_idle");
  endtask
  task automatic test_hold_d();
    logic [3:0] exp_row;
    key_code = 4'hD;
    col = 4'b1110;
    press_valid = 1'b1;
    tick();
    press_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) key_code = 4'h1;
      exp_row = (k >= 2 && k <= 9) ? 4'b1110 : 4'b1111;
      n_vec++; if (row !== exp_row) begin n_err++; $display("FAIL holdD_row k=%0d: got %b, required %b", k, row, exp_row); end
      n_vec++; if (done !== (k == 13)) begin n_err++; $display("FAIL holdD_done k=%0d: got %b, required %b", k, done, k == 13); end
      n_vec++; if (busy !== (k < 13)) begin n_err++; $display("FAIL holdD_busy k=%0d: got %b, required %b", k, busy, k < 13); end
    end
  endtask
  task automatic test_back_to_back();
    logic [3:0] exp_row;
    wait_idle("b2b_start");
    key_code = 4'h1;
    col = 4'b0111;
    press_valid = 1'b1;
    tick();
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) key_code = 4'h0;
      exp_row = (k >= 2 && k <= 9) ? 4'b0111 : 4'b1111;
      n_vec++; if (row !== exp_row) begin n_err++; $display("FAIL b2b_row k=%0d: got %b, required %b", k, row, exp_row); end
      if (k == 13) begin
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b, required 1", done); end
        n_vec++; if (press_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b, required 1", press_ready); end
      end
      if (k == 14) begin
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_second_accept: busy %b, required 1", busy); end
        n_vec++; if (press_ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_ready: got %b, required 0", press_ready); end
      end
    end
    press_valid = 1'b0;
    col = 4'b1011;
    tick();
    tick();
    n_vec++; if (row !== 4'hF) begin n_err++; $display("FAIL key0_wrong_col: got %b, required 1111", row); end
    col = 4'b0111;
    tick();
    n_vec++; if (row !== 4'b1110) begin n_err++; $display("FAIL key0_row: got %b, required 1110", row); end
    wait_idle("b2b_idle");
  endtask
  task automatic test_reset_mid_press();
    logic seen_done, bad_row;
    key_code = 4'h5;
    col = 4'b1011;
    press_valid = 1'b1;
    tick();
    press_valid = 1'b0;
    tick();
    tick();
    tick();
    n_vec++; if (row !== 4'b1011) begin n_err++; $display("FAIL mid_pressed: got %b, required 1011", row); end
    reset = 1'b1;
    tick();
    n_vec++; if (row !== 4'hF) begin n_err++; $display("FAIL mid_reset_row: got %b, required 1111", row); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b, required 0", busy); end
    n_vec++; if (press_ready !== 1'b0) begin n_err++; $display("FAIL mid_reset_ready: got %b, required 0", press_ready); end
    reset = 1'b0;
    #1;
    n_vec++; if (press_ready !== 1'b1) begin n_err++; $display("FAIL mid_after_ready: got %b, required 1", press_ready); end
    seen_done = 1'b0;
    bad_row = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      seen_done |= done;
      bad_row |= row !== 4'hF;
    end
    n_vec++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL mid_no_done: saw done %b, required 0", seen_done); end
    n_vec++; if (bad_row !== 1'b0) begin n_err++; $display("FAIL mid_row_quiet: row left 1111 %b, required 0", bad_row); end
  endtask
`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [7:0] m_lfsr;
  always @(posedge clk) m_lfsr <= reset ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  task automatic test_bounce();
    logic [7:0] l [0:16];
    logic [3:0] exp_row;
    wait_idle("bounce_start");
    key_code = 4'hD;
    col = 4'b1110;
    press_valid = 1'b1;
    tick();
    press_valid = 1'b0;
    l[0] = m_lfsr;
    for (int k = 1; k <= 16; k++) begin
      tick();
      l[k] = m_lfsr;
      if (k == 2 || k == 3 || k == 10 || k == 11) exp_row = l[k-2][0] ? 4'b1110 : 4'b1111;
      else exp_row = (k >= 4 && k <= 9) ? 4'b1110 : 4'b1111;
      n_vec++; if (row !== exp_row) begin n_err++; $display("FAIL bounce_row k=%0d: got %b, required %b", k, row, exp_row); end
      n_vec++; if (done !== (k == 14)) begin n_err++; $display("FAIL bounce_done k=%0d: got %b, required %b", k, done, k == 14); end
    end
  endtask
`endif
  initial begin
    test_reset();
`ifdef KEYPAD_EMU_BOUNCE_EN
    test_bounce();
`else
    test_col_track();
    test_hold_d();
    test_back_to_back();
    test_reset_mid_press();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
